// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the systolic skew feeder.
// Holds the controller state encoding, default sizing and a lane-slice helper.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DRAIN   = 2'd2,
        DONE_ST = 2'd3
    } feeder_state_t;

    localparam int DEF_PE_DATA_WIDTH = 16;
    localparam int DEF_DEPTH         = 4;
    localparam int DEF_COUNT_WIDTH   = 5;

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane_delay_line.sv
// Per-lane delay line: a STAGES-deep shift register carrying a data word and
// its valid bit. STAGES = 0 degenerates to a wire. any_valid_o reports whether
// any internal stage still holds a valid word, so the owner can tell when the
// line has drained.
module lane_delay_line #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             any_valid_o
);

    if (STAGES == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk, reset};
        assign data_o      = data_i;
        assign valid_o     = valid_i;
        assign any_valid_o = 1'b0;
    end else begin : g_shift
        logic [WIDTH-1:0]  data_q [STAGES];
        logic [STAGES-1:0] valid_q;

        // Shift data and valid one stage per clock; reset empties the whole line.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < STAGES; s++) begin
                    data_q[s]  <= '0;
                    valid_q[s] <= 1'b0;
                end
            end else begin
                data_q[0]  <= data_i;
                valid_q[0] <= valid_i;
                for (int s = 1; s < STAGES; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign data_o      = data_q[STAGES-1];
        assign valid_o     = valid_q[STAGES-1];
        assign any_valid_o = |valid_q;
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic skew feeder: captures one DEPTH-lane block per accepted in_valid
// into a common stage-0 register, then delays lane i by i further cycles so
// the PE array sees a diagonal wavefront. Bubbles carry zero data. A small
// controller counts blocks and turns the loader's done into a done that only
// fires once every accepted word has left the pipeline.
module systolic_skew_feeder
    import feeder_pkg::*;
#(
    parameter int PE_DATA_WIDTH = DEF_PE_DATA_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]   in_data,
    input  logic                             in_valid,
    input  logic                             in_done,
    output logic [PE_DATA_WIDTH*DEPTH-1:0]   out_data,
    output logic [DEPTH-1:0]                 out_valid,
    output logic [COUNT_WIDTH-1:0]           block_count,
    output logic                             busy,
    output logic                             done
);

    feeder_state_t                   state_q, state_d;
    logic                            busy_q, done_q;
    logic [COUNT_WIDTH-1:0]          count_q;
    logic [PE_DATA_WIDTH*DEPTH-1:0]  s0_data_q;
    logic [DEPTH-1:0]                s0_valid_q;
    logic [PE_DATA_WIDTH*DEPTH-1:0]  lane_data;
    logic [DEPTH-1:0]                lane_valid;
    logic [DEPTH-1:0]                lane_any;
    logic                            accept;
    logic                            pipe_busy;

    // Blocks are only taken while a job is open; DRAIN and DONE_ST ignore in_valid.
    assign accept    = in_valid && ((state_q == IDLE) || (state_q == STREAM));
    assign pipe_busy = (|s0_valid_q) || (|lane_any);

    // Common stage-0 capture: an accepted block, otherwise a zero bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_data_q  <= '0;
            s0_valid_q <= '0;
        end else if (accept) begin
            s0_data_q  <= in_data;
            s0_valid_q <= '1;
        end else begin
            s0_data_q  <= '0;
            s0_valid_q <= '0;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        lane_delay_line #(
            .WIDTH  (PE_DATA_WIDTH),
            .STAGES (i)
        ) u_delay (
            .clk         (clk),
            .reset       (reset),
            .data_i      (s0_data_q[lane_lsb(i, PE_DATA_WIDTH) +: PE_DATA_WIDTH]),
            .valid_i     (s0_valid_q[i]),
            .data_o      (lane_data[lane_lsb(i, PE_DATA_WIDTH) +: PE_DATA_WIDTH]),
            .valid_o     (lane_valid[i]),
            .any_valid_o (lane_any[i])
        );

        assign out_data[lane_lsb(i, PE_DATA_WIDTH) +: PE_DATA_WIDTH] =
            lane_valid[i] ? lane_data[lane_lsb(i, PE_DATA_WIDTH) +: PE_DATA_WIDTH]
                          : '0;
    end

    assign out_valid = lane_valid;

    // Next-state logic; a done arriving with a block still captures that block first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_done) begin
                    state_d = DRAIN;
                end else if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (in_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with registered busy/done and the per-job block counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == STREAM) || (state_d == DRAIN);
            done_q  <= (state_d == DONE_ST);
            if (state_q == DONE_ST) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign block_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder. The driver issues one input set
// per clock and, from a timing-level model of the feeder (lane i of a block
// accepted at edge k shows up in cycle k+i; done lands one cycle after both
// the in_done edge and the DEPTH+1 drain window), pushes what each output
// should look like. An independent monitor pops and compares on falling edges.
module tb_systolic_skew_feeder;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int CW = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic [W*D-1:0] in_data;
   logic           in_valid;
   logic           in_done;
   logic [W*D-1:0] out_data;
   logic [D-1:0]   out_valid;
   logic [CW-1:0]  block_count;
   logic           busy;
   logic           done;

   typedef struct {
      int           cyc;
      logic [W-1:0] data;
   } laneExp_t;

   typedef struct {
      int            cyc;
      logic          busy;
      logic          done;
      logic [CW-1:0] count;
   } statExp_t;

   laneExp_t laneQ[D][$];
   statExp_t statQ[$];

   int            vectors     = 0;
   int            miscompares = 0;
   int            edgeIdx     = -1;
   bit            jobActive   = 1'b0;
   bit            doneIssued  = 1'b0;
   int            doneCycle   = 0;
   int            lastAccept  = -100;
   logic [CW-1:0] modelCount  = '0;

   statExp_t      monS;
   logic          monV;
   logic [W-1:0]  monD;

   systolic_skew_feeder #(
      .PE_DATA_WIDTH (W),
      .DEPTH         (D),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_done     (in_done),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .block_count (block_count),
      .busy        (busy),
      .done        (done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Reference model for one rising edge: decides whether the inputs are
   // accepted, schedules each lane's appearance and records the status outputs
   // expected in the cycle that follows this edge.
   task automatic modelEdge(input logic v, input logic [W*D-1:0] data,
                            input logic dn, input logic rst);
      statExp_t s;
      if (rst) begin
         for (int i = 0; i < D; i++) laneQ[i].delete();
         jobActive  = 1'b0;
         doneIssued = 1'b0;
         modelCount = '0;
         lastAccept = -100;
      end else if (doneIssued && edgeIdx == doneCycle + 1) begin
         jobActive  = 1'b0;
         doneIssued = 1'b0;
         modelCount = '0;
         lastAccept = -100;
      end else if (!doneIssued) begin
         if (v) begin
            for (int i = 0; i < D; i++) begin
               laneExp_t e;
               e.cyc  = edgeIdx + i;
               e.data = data[i*W +: W];
               laneQ[i].push_back(e);
            end
            modelCount = modelCount + 1'b1;
            lastAccept = edgeIdx;
            jobActive  = 1'b1;
         end
         if (dn) begin
            jobActive  = 1'b1;
            doneIssued = 1'b1;
            doneCycle  = (edgeIdx + 1 > lastAccept + D + 1) ? edgeIdx + 1
                                                            : lastAccept + D + 1;
         end
      end
      s.cyc   = edgeIdx;
      s.busy  = jobActive && !(doneIssued && edgeIdx >= doneCycle);
      s.done  = doneIssued && (edgeIdx == doneCycle);
      s.count = modelCount;
      statQ.push_back(s);
   endtask

   // Drive one set of inputs across a rising edge, then update the model.
   task automatic applyStimulus(input logic v, input logic [W*D-1:0] data,
                                input logic dn, input logic rst);
      reset    = rst;
      in_valid = v;
      in_data  = data;
      in_done  = dn;
      @(posedge clk);
      edgeIdx++;
      modelEdge(v, data, dn, rst);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic randBlocks(input int n);
      repeat (n) applyStimulus(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
   endtask

   // One comparison: counts it and reports a miss.
   task automatic checkOutput(input string name, input int cyc,
                              input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s @cycle %0d: got %h, want %h", name, cyc, got, want);
      end
   endtask

   // Monitor: on every falling edge pop the status expected for the cycle just
   // entered and compare every lane against whatever the scoreboard scheduled.
   always @(negedge clk) begin
      if (statQ.size() > 0) begin
         monS = statQ.pop_front();
         checkOutput("busy",        monS.cyc, 64'(busy),        64'(monS.busy));
         checkOutput("done",        monS.cyc, 64'(done),        64'(monS.done));
         checkOutput("block_count", monS.cyc, 64'(block_count), 64'(monS.count));
         for (int i = 0; i < D; i++) begin
            monV = 1'b0;
            monD = '0;
            if (laneQ[i].size() > 0 && laneQ[i][0].cyc == monS.cyc) begin
               monV = 1'b1;
               monD = laneQ[i][0].data;
               void'(laneQ[i].pop_front());
            end
            checkOutput($sformatf("lane%0d_valid", i), monS.cyc,
                        64'(out_valid[i]), 64'(monV));
            checkOutput($sformatf("lane%0d_data", i), monS.cyc,
                        64'(out_data[i*W +: W]), 64'(monD));
         end
      end
   end

   // Directed scenarios first, then a randomized stretch, then a final flush.
   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_done  = 1'b0;
      in_data  = '0;

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] single block");
      applyStimulus(1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
      idle(6);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(8);

      $display("[TB] sixteen back-to-back blocks");
      randBlocks(16);
      idle(2);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(10);

      $display("[TB] counter wrap with 33 blocks");
      randBlocks(33);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(10);

      $display("[TB] done two cycles after last block");
      randBlocks(11);
      idle(1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(10);

      $display("[TB] block and done together, then blocks during drain");
      randBlocks(3);
      applyStimulus(1'b1, {$urandom(), $urandom()}, 1'b1, 1'b0);
      randBlocks(4);
      idle(8);

      $display("[TB] reset mid-stream");
      randBlocks(2);
      applyStimulus(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b1);
      idle(8);

      $display("[TB] empty job");
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(5);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       {$urandom(), $urandom()},
                       1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 99) < 2));
      end
      idle(12);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(12);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Sits directly downstream of the RAM block loader and upstream of the 4x4 brightness PE array.
- Accepts one DEPTH-lane block per in_valid pulse and re-times it into the diagonal "wavefront" order the systolic array needs: lane i is delayed i cycles relative to lane 0.
- Zero-fills bubbles, counts blocks, and converts the loader's done into a drained-pipeline done.

Parameters:
- PE_DATA_WIDTH, 16, width of one lane word.
- DEPTH, 4, number of lanes; equals the array dimension.
- COUNT_WIDTH, 5, width of the block counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  PE_DATA_WIDTH*DEPTH  block from loader; lane i at bits [i*PE_DATA_WIDTH +: PE_DATA_WIDTH].
- in_valid  input  1  block valid, sampled on the rising clk edge.
- in_done  input  1  loader finished; single-cycle pulse.
- out_data  output  PE_DATA_WIDTH*DEPTH  skewed lanes to the array, same lane packing as in_data.
- out_valid  output  DEPTH  per-lane valid.
- block_count  output  COUNT_WIDTH  blocks accepted since the last reset or the last return to IDLE.
- busy  output  1  high in STREAM or DRAIN.
- done  output  1  one-cycle pulse once all accepted data has left the pipeline.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: out_data = 0, out_valid = 0, block_count = 0, busy = 0, done = 0; all delay lines are cleared; state = IDLE.
- Reset mid-operation: in-flight data is discarded and no done is produced.
- Input capture:
  - When in_valid = 1 in IDLE or STREAM, all lanes are registered into stage 0.
  - When in_valid = 0, stage 0 is loaded with data 0 and valid 0 (bubble).
- Latency and skew:
  - Lane i appears on out_data with out_valid[i] = 1 exactly 1+i cycles after the in_valid edge.
  - Lane 0 has latency 1; lane DEPTH-1 has latency DEPTH.
- Bubble handling:
  - Any lane whose valid bit is 0 drives 0 on its data slice.
  - X or stale values are never presented to the array.
- Throughput and overlap: back-to-back in_valid (one block per cycle) is supported with no stalls; successive blocks overlap diagonally. There is no backpressure.
- block_count:
  - Increments on each accepted in_valid.
  - Wraps modulo 2^COUNT_WIDTH.
  - Clears when the FSM enters IDLE from DONE_ST.
- FSM states: IDLE, STREAM, DRAIN, DONE_ST.
- FSM transitions:
  - IDLE -> STREAM on in_valid (that block is captured).
  - IDLE -> DRAIN on in_done without in_valid; this is the empty job, and done follows after DRAIN empties.
  - STREAM -> DRAIN on in_done. If in_valid and in_done are asserted in the same cycle, the block is captured first and then draining begins.
  - DRAIN -> DONE_ST when no valid bit remains in any delay-line stage.
  - DONE_ST -> IDLE after one cycle. done = 1 only while in DONE_ST.
- Inputs ignored in some states:
  - in_valid is ignored in DRAIN and DONE_ST; nothing is captured and block_count does not change.
  - in_done is ignored outside IDLE and STREAM.
- busy is high exactly in STREAM and DRAIN.
- Drain timing: with the last block accepted at edge t, done pulses at edge t+DEPTH+1 or later, and never while any out_valid bit is 1.

Decomposition:
- Package feeder_pkg:
  - feeder_state_t enum holding the four states.
  - Default-parameter localparams.
  - A lane-slice helper function.
- Sub-module lane_delay_line #(WIDTH, STAGES):
  - Shift register carrying data and valid, with synchronous clear.
  - STAGES = 0 is a pass-through.
  - Instantiated once per lane with STAGES = i, after the common stage-0 capture register.

Test Plan:
- Single block: in_valid at cycle 0 with lanes {0x0004, 0x0003, 0x0002, 0x0001} (lane3..lane0).
  - Required: out_valid = 0001 with lane0 = 0x0001 at cycle 1; 0010 with lane1 = 0x0002 at cycle 2; 0100 at cycle 3; 1000 with lane3 = 0x0004 at cycle 4.
  - All other lane slices are 0 throughout.
- Back-to-back: 16 consecutive in_valid blocks.
  - Required: at steady state out_valid = 1111 every cycle; block_count = 16 and wraps to 0 at 32 with COUNT_WIDTH = 5.
- Done after drain: last block at cycle 10, in_done at cycle 12.
  - Required: done pulses exactly once, after cycle 14 (the last lane-3 output); busy is low the cycle after done.
- Simultaneous events:
  - in_valid and in_done in the same cycle: that block appears fully skewed before done.
  - in_valid during DRAIN: ignored; block_count unchanged.
- Reset mid-stream: reset asserted at cycle 2 of a block.
  - Required: next cycle all outputs are 0, state is IDLE, no done pulse.
- Empty job: in_done in IDLE.
  - Required: done pulses with block_count = 0 and no out_valid activity.
